// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo move sequencer slice.
package servo_pkg;
  localparam int N_SERVO    = 8;
  localparam int W          = 32;
  localparam int D_MIN_DEF  = 50000;
  localparam int D_MAX_DEF  = 100000;
  localparam int D_INIT_DEF = 75000;

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;
  typedef logic [2:0]   servo_id_t;
  typedef logic [W-1:0] duty_t;
endpackage

// File: rtl/servo_move_sequencer_if.sv
// Move-command handshake between the move scheduler (master) and the sequencer (slave).
interface servo_move_sequencer_if #(
  parameter int W = servo_pkg::W
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  servo_pkg::servo_id_t cmd_id;
  logic [W-1:0]         cmd_target;
  logic [15:0]          cmd_step;
  logic                 cmd_en;

  modport master (output cmd_valid, cmd_id, cmd_target, cmd_step, cmd_en,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_id, cmd_target, cmd_step, cmd_en,
                  output cmd_ready);
endinterface

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; frame_tick marks the last cycle of each frame.
module servo_frame_timer #(
  parameter int FRAME_CLKS = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);
  localparam int CW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CLKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign frame_tick = (cnt == LAST);
endmodule

// File: rtl/servo_move_sequencer.sv
// Eight-channel servo sequencer: owns period/duty/enable and ramps one servo per command,
// changing duty only at frame boundaries.
module servo_move_sequencer
  import servo_pkg::*;
#(
  parameter int N_SERVO    = servo_pkg::N_SERVO,
  parameter int W          = servo_pkg::W,
  parameter int FRAME_CLKS = 1000000,
  parameter int D_MIN      = servo_pkg::D_MIN_DEF,
  parameter int D_MAX      = servo_pkg::D_MAX_DEF,
  parameter int D_INIT     = servo_pkg::D_INIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  servo_move_sequencer_if.slave  cmd,
  input  logic                   abort,
  output logic [W-1:0]           period_out,
  output logic [N_SERVO*W-1:0]   duty_flat,
  output logic [N_SERVO-1:0]     enable,
  output logic                   frame_tick,
  output logic                   busy,
  output logic                   done,
  output servo_id_t              done_id,
  output logic                   clamped
);
  localparam logic [W-1:0] DMIN  = W'(D_MIN);
  localparam logic [W-1:0] DMAX  = W'(D_MAX);
  localparam logic [W-1:0] DINIT = W'(D_INIT);

  state_t       state;
  logic [W-1:0] duty [N_SERVO];
  servo_id_t    id_q;
  logic [15:0]  step_q;
  logic [W-1:0] tgt_q;
  logic         clamp_q;

  logic [W-1:0] tgt_c;
  logic         clamp_c;
  logic         up;
  logic [W-1:0] cur, diff, step_w, mv, nxt;

  servo_frame_timer #(.FRAME_CLKS(FRAME_CLKS)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

  assign period_out    = W'(FRAME_CLKS - 1);
  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == RAMP);

  always_comb begin
    duty_flat = '0;
    for (int unsigned i = 0; i < N_SERVO; i++) duty_flat[i*W +: W] = duty[i];
  end

  always_comb begin
    tgt_c = cmd.cmd_target;
    if (cmd.cmd_target < DMIN)      tgt_c = DMIN;
    else if (cmd.cmd_target > DMAX) tgt_c = DMAX;
    clamp_c = (tgt_c != cmd.cmd_target);
  end

  // |target - duty| always fits in W bits and the move never exceeds it, so no wrap
  always_comb begin
    cur    = duty[id_q];
    up     = (tgt_q > cur);
    diff   = up ? (tgt_q - cur) : (cur - tgt_q);
    step_w = W'(step_q);
    mv     = (step_w < diff) ? step_w : diff;
    nxt    = up ? (cur + mv) : (cur - mv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      for (int unsigned i = 0; i < N_SERVO; i++) duty[i] <= DINIT;
      enable  <= '0;
      id_q    <= '0;
      step_q  <= '0;
      tgt_q   <= '0;
      clamp_q <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      clamped <= 1'b0;
    end else begin
      done    <= 1'b0;
      clamped <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            id_q    <= cmd.cmd_id;
            step_q  <= cmd.cmd_step;
            tgt_q   <= tgt_c;
            clamp_q <= clamp_c;
            enable[cmd.cmd_id] <= cmd.cmd_en;
            if (!cmd.cmd_en || cmd.cmd_step == '0 || duty[cmd.cmd_id] == tgt_c) begin
              if (cmd.cmd_en) duty[cmd.cmd_id] <= tgt_c;
              state   <= DONE;
              done    <= 1'b1;
              done_id <= cmd.cmd_id;
              clamped <= clamp_c;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (abort || (frame_tick && nxt == tgt_q)) begin
            if (!abort) duty[id_q] <= nxt;
            state   <= DONE;
            done    <= 1'b1;
            done_id <= id_q;
            clamped <= clamp_q;
          end else if (frame_tick) begin
            duty[id_q] <= nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_servo_move_sequencer.sv
// Scoreboard bench for servo_move_sequencer: stimulus pushes expected completions, monitor checks them.
module tb_servo_move_sequencer;
  localparam int NS = 8;
  localparam int WW = 32;
  localparam int FC = 100;
  localparam int DMIN = 10;
  localparam int DMAX = 50;
  localparam int DINIT = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic [WW-1:0]    period_out;
  logic [NS*WW-1:0] duty_flat;
  logic [NS-1:0]    enable;
  logic frame_tick, busy, done, clamped;
  logic [2:0] done_id;

  servo_move_sequencer_if #(.W(WW)) cmd_if ();

  servo_move_sequencer #(
    .N_SERVO(NS), .W(WW), .FRAME_CLKS(FC),
    .D_MIN(DMIN), .D_MAX(DMAX), .D_INIT(DINIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .abort(abort),
    .period_out(period_out), .duty_flat(duty_flat), .enable(enable),
    .frame_tick(frame_tick), .busy(busy), .done(done), .done_id(done_id),
    .clamped(clamped)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] id;
    logic       cl;
    logic [255:0] duty;
    logic [7:0] en;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   mdl_duty [NS];
  logic [NS-1:0] mdl_en;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] pack_duty();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v[i*WW +: WW] = 32'(mdl_duty[i]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) mdl_duty[i] = DINIT;
    mdl_en = '0;
  endfunction

  // k-th frame-tick cycle strictly after cycle h (ticks at cycles where cyc % FC == FC-1)
  function automatic int tick_k(input int h, input int k);
    return h + 1 + (FC - 1 - ((h + 1) % FC)) + (k - 1) * FC;
  endfunction

  function automatic void model_cmd(input int h, input int id, input longint tgt,
                                    input int st, input bit en, input int a_off);
    int t, d0, diff, n, k, dcyc;
    bit cl;
    exp_t e;
    t  = (tgt < DMIN) ? DMIN : (tgt > DMAX) ? DMAX : int'(tgt);
    cl = (longint'(t) != tgt);
    d0 = mdl_duty[id];
    dcyc = h + 1;
    if (!en) begin
      mdl_en[id] = 1'b0;
    end else begin
      mdl_en[id] = 1'b1;
      if (st == 0 || d0 == t) begin
        mdl_duty[id] = t;
      end else begin
        diff = (t > d0) ? t - d0 : d0 - t;
        n = (diff + st - 1) / st;
        k = 0;
        if (a_off > 0)
          for (int c = h + 1; c < h + a_off; c++) if (c % FC == FC - 1) k++;
        if (a_off > 0 && k < n) begin
          mdl_duty[id] = (t > d0) ? d0 + k * st : d0 - k * st;
          dcyc = h + a_off + 1;
        end else begin
          mdl_duty[id] = t;
          dcyc = tick_k(h, n) + 1;
        end
      end
    end
    e.cyc = dcyc; e.id = 3'(id); e.cl = cl; e.duty = pack_duty(); e.en = mdl_en;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("frame_tick", 256'(frame_tick), 256'((cyc % FC) == FC - 1));
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 256'(done), 256'(0));
        end else begin
          mon_e = q.pop_front();
          chk("done_cycle", 256'(cyc), 256'(mon_e.cyc));
          chk("done_id", 256'(done_id), 256'(mon_e.id));
          chk("clamped", 256'(clamped), 256'(mon_e.cl));
          chk("duty_flat", duty_flat, mon_e.duty);
          chk("enable", 256'(enable), 256'(mon_e.en));
          chk("ready_in_done", 256'(cmd_if.cmd_ready), 256'(0));
          chk("busy_in_done", 256'(busy), 256'(0));
        end
      end else begin
        chk("clamped_without_done", 256'(clamped), 256'(0));
      end
    end
  end

  task automatic chk_reset(input string tag);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < NS; i++) d[i*WW +: WW] = 32'(DINIT);
    chk({tag, "_period"}, 256'(period_out), 256'(FC - 1));
    chk({tag, "_duty"}, duty_flat, d);
    chk({tag, "_enable"}, 256'(enable), 256'(0));
    chk({tag, "_ready"}, 256'(cmd_if.cmd_ready), 256'(1));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_done"}, 256'(done), 256'(0));
    chk({tag, "_done_id"}, 256'(done_id), 256'(0));
    chk({tag, "_clamped"}, 256'(clamped), 256'(0));
    chk({tag, "_frame_tick"}, 256'(frame_tick), 256'(0));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_if.cmd_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_if.cmd_ready) chk("ready_timeout", 256'(cmd_if.cmd_ready), 256'(1));
  endtask

  // a_off > 0: abort in cycle h+a_off; a_off < 0: abort in the cycle of tick number -a_off
  task automatic issue(input int id, input longint tgt, input int st, input bit en, input int a_off);
    int h, a;
    wait_ready();
    if (!cmd_if.cmd_ready) return;
    h = cyc;
    a = (a_off < 0) ? tick_k(h, -a_off) - h : a_off;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_id     = 3'(id);
    cmd_if.cmd_target = tgt[31:0];
    cmd_if.cmd_step   = 16'(st);
    cmd_if.cmd_en     = en;
    model_cmd(h, id, tgt, st, en, a);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    if (a > 0) begin
      while (cyc < h + a) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  initial begin
    int h, n, id, st, a;
    longint tg;
    bit en;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_id = '0; cmd_if.cmd_target = '0;
    cmd_if.cmd_step = '0; cmd_if.cmd_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("in_reset");
    rst_n = 1'b1;
    chk_reset("release");

    issue(3, 40, 4, 1'b1, 0);
    issue(5, 200, 0, 1'b1, 0);
    issue(1, 10, 7, 1'b1, -2);
    issue(2, 25, 0, 1'b1, 0);

    // disable id 2 with cmd_valid held through DONE: second acceptance only back in IDLE
    wait_ready();
    h = cyc;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_id = 3'd2; cmd_if.cmd_target = 32'd40;
    cmd_if.cmd_step = 16'd0; cmd_if.cmd_en = 1'b0;
    model_cmd(h, 2, 40, 0, 1'b0, 0);
    @(negedge clk);
    chk("ready_low_in_done", 256'(cmd_if.cmd_ready), 256'(0));
    @(negedge clk);
    model_cmd(h + 2, 2, 40, 0, 1'b0, 0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;

    for (int i = 0; i < 20; i++) begin
      id = int'($urandom_range(0, 7));
      tg = ($urandom_range(0, 9) == 0) ? 64'h0000_0000_FFFF_FFF0 : longint'($urandom_range(0, 70));
      st = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 20));
      en = ($urandom_range(0, 5) != 0);
      case ($urandom_range(0, 3))
        0:       a = 0 - int'($urandom_range(1, 3));
        1:       a = int'($urandom_range(1, 400));
        default: a = 0;
      endcase
      issue(id, tg, st, en, a);
    end

    // reset in the middle of a ramp on id 6: state discarded, no done afterwards
    issue(6, (mdl_duty[6] >= 30) ? 10 : 50, 3, 1'b1, 0);
    repeat (150) @(negedge clk);
    chk("busy_before_reset", 256'(busy), 256'(1));
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reset("re_release");
    repeat (300) @(negedge clk);

    issue(0, 5, 6, 1'b1, 0);
    issue(7, 45, 0, 1'b1, 0);

    n = 0;
    while (q.size() != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 256'(q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
